// File: rtl/numeric_led_display_pkg.sv
// numeric_led_display_pkg: glyph codes, digit count, segment bit positions and monitor FSM states
// Shared by the display driver and the display monitor.
package numeric_led_display_pkg;
    localparam int NUM_DIGITS = 4;
    // Bit positions inside a segment byte (a..g, dp), MSB first.
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;
    localparam logic [7:0] GLYPH_0 = 8'hFC;
    localparam logic [7:0] GLYPH_1 = 8'h60;
    localparam logic [7:0] GLYPH_2 = 8'hDA;
    localparam logic [7:0] GLYPH_3 = 8'hF2;
    localparam logic [7:0] GLYPH_4 = 8'h66;
    localparam logic [7:0] GLYPH_5 = 8'hB6;
    localparam logic [7:0] GLYPH_6 = 8'hBE;
    localparam logic [7:0] GLYPH_7 = 8'hE0;
    localparam logic [7:0] GLYPH_8 = 8'hFE;
    localparam logic [7:0] GLYPH_9 = 8'hE6;
    localparam logic [7:0] GLYPH_A = 8'hEE;
    localparam logic [7:0] GLYPH_B = 8'h3E;
    localparam logic [7:0] GLYPH_C = 8'h9C;
    localparam logic [7:0] GLYPH_D = 8'h7A;
    localparam logic [7:0] GLYPH_E = 8'h9E;
    localparam logic [7:0] GLYPH_F = 8'h8E;
    localparam logic [7:0] GLYPHS [16] = '{
        GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
        GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
    };
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;
endpackage

// File: rtl/numeric_led_display_monitor_seven_seg_decoder.sv
// seven_seg_decoder: maps a 7-bit a..g segment pattern back to its hex nibble
// Ports: pattern (a in bit 6 .. g in bit 0), nibble (decoded value), valid (pattern is a hex glyph).
module seven_seg_decoder
    import numeric_led_display_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       valid
);
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i][SEG_A:SEG_G]) begin
                nibble = 4'(i);
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/numeric_led_display_monitor.sv
// numeric_led_display_monitor: rebuilds the LED driver's shift-register images and publishes the displayed 16-bit number
// Ports: i_clk, i_reset_n (async active-low); i_shifter_{a,b}_{ds,cp,mr_n} snooped serial pins;
// o_number (last complete number), o_valid (update pulse), o_digit_mask (digits of current frame),
// o_decode_error / o_select_error (one-cycle pulses on a bad glyph / non one-hot select).
module numeric_led_display_monitor
    import numeric_led_display_pkg::*;
#(
    parameter int   SETTLE_CYCLES = 16,
    parameter logic COMMON_ANODE  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_shifter_a_ds,
    input  logic        i_shifter_a_cp,
    input  logic        i_shifter_a_mr_n,
    input  logic        i_shifter_b_ds,
    input  logic        i_shifter_b_cp,
    input  logic        i_shifter_b_mr_n,
    output logic [15:0] o_number,
    output logic        o_valid,
    output logic [3:0]  o_digit_mask,
    output logic        o_decode_error,
    output logic        o_select_error
);
    // Pin order in the synchronizer: {a_ds, a_cp, a_mr_n, b_ds, b_cp, b_mr_n}
    logic [5:0] sync1, sync2;
    logic       cp_a_q, cp_b_q;
    logic       edge_a, edge_b, any_edge;
    logic [7:0] img_a, img_b, seg, sel_img;
    logic [3:0] sel, nibble, mask_n;
    logic       one_hot, glyph_ok, capture, store, full;
    logic [1:0] idx;
    logic [15:0] slots, slots_n;
    logic [7:0] cnt, cnt_n;
    state_t     state, state_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            cp_a_q <= 1'b0;
            cp_b_q <= 1'b0;
        end else begin
            sync1  <= {i_shifter_a_ds, i_shifter_a_cp, i_shifter_a_mr_n,
                       i_shifter_b_ds, i_shifter_b_cp, i_shifter_b_mr_n};
            sync2  <= sync1;
            cp_a_q <= sync2[4];
            cp_b_q <= sync2[1];
        end
    end

    assign edge_a   = sync2[4] & ~cp_a_q;
    assign edge_b   = sync2[1] & ~cp_b_q;
    assign any_edge = edge_a | edge_b;

    // Clear wins over a coincident shift, mirroring the 74HC595-style register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            img_a <= 8'h00;
            img_b <= 8'h00;
        end else begin
            img_a <= !sync2[3] ? 8'h00 : edge_a ? {img_a[6:0], sync2[5]} : img_a;
            img_b <= !sync2[0] ? 8'h00 : edge_b ? {img_b[6:0], sync2[2]} : img_b;
        end
    end

    assign seg     = COMMON_ANODE ? ~img_a : img_a;
    assign sel_img = COMMON_ANODE ? ~img_b : img_b;
    assign sel     = sel_img[3:0];
    assign one_hot = (sel != 4'h0) && ((sel & (sel - 4'h1)) == 4'h0);
    assign idx     = sel[1] ? 2'd1 : sel[2] ? 2'd2 : sel[3] ? 2'd3 : 2'd0;

    seven_seg_decoder u_dec (
        .pattern (seg[SEG_A:SEG_G]),
        .nibble  (nibble),
        .valid   (glyph_ok)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            cnt   <= 8'h00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (any_edge) begin
                    state_n = ST_SETTLE;
                    cnt_n   = 8'h00;
                end
            end
            ST_SETTLE: begin
                if (any_edge)
                    cnt_n = 8'h00;
                else if (cnt == 8'(SETTLE_CYCLES - 1))
                    state_n = ST_CAPTURE;
                else
                    cnt_n = cnt + 8'h01;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign capture = state == ST_CAPTURE;
    assign store   = capture & one_hot & glyph_ok;

    always_comb begin
        slots_n = slots;
        if (store)
            slots_n[idx*4 +: 4] = nibble;
    end

    assign mask_n = o_digit_mask | (store ? 4'(1) << idx : 4'h0);
    assign full   = store && (mask_n == 4'hF);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slots          <= 16'h0000;
            o_number       <= 16'h0000;
            o_valid        <= 1'b0;
            o_digit_mask   <= 4'h0;
            o_decode_error <= 1'b0;
            o_select_error <= 1'b0;
        end else begin
            slots          <= slots_n;
            o_number       <= full ? slots_n : o_number;
            o_valid        <= full;
            o_digit_mask   <= full ? 4'h0 : mask_n;
            o_decode_error <= capture & one_hot & ~glyph_ok;
            o_select_error <= capture & ~one_hot;
        end
    end
endmodule

// File: tb/tb_numeric_led_display_monitor.sv
// tb_numeric_led_display_monitor: directed self-checking bench for numeric_led_display_monitor
module tb_numeric_led_display_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_ds = 1'b0, a_cp = 1'b0, a_mr_n = 1'b1;
    logic        b_ds = 1'b0, b_cp = 1'b0, b_mr_n = 1'b1;
    logic [15:0] number;
    logic        valid, dec_err, sel_err;
    logic [3:0]  mask;
    int          n_cmp = 0, n_bad = 0;
    int          n_valid = 0, n_dec = 0, n_sel = 0;
    logic [7:0]  glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    logic [7:0]  a_img, b_img;

    always #20 clk = ~clk;

    numeric_led_display_monitor dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_shifter_a_ds   (a_ds),
        .i_shifter_a_cp   (a_cp),
        .i_shifter_a_mr_n (a_mr_n),
        .i_shifter_b_ds   (b_ds),
        .i_shifter_b_cp   (b_cp),
        .i_shifter_b_mr_n (b_mr_n),
        .o_number         (number),
        .o_valid          (valid),
        .o_digit_mask     (mask),
        .o_decode_error   (dec_err),
        .o_select_error   (sel_err)
    );

    // Pulse counters: a pulse held two cycles counts twice.
    always @(negedge clk) begin
        n_valid <= n_valid + int'(valid);
        n_dec   <= n_dec + int'(dec_err);
        n_sel   <= n_sel + int'(sel_err);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic a, input logic b);
        a_ds = a;
        b_ds = b;
        repeat (2) @(negedge clk);
        a_cp = 1'b1;
        b_cp = 1'b1;
        repeat (2) @(negedge clk);
        a_cp = 1'b0;
        b_cp = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_raw(input logic [7:0] a, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(a[i], b[i]);
        repeat (30) @(negedge clk);
    endtask

    // Common-anode images: both bytes arrive inverted.
    task automatic send_digit(input int d, input int n);
        a_img = ~glyph[n];
        b_img = ~(8'h01 << d);
        send_raw(a_img, b_img);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("reset_number", 32'(number), 32'h0);
        chk("reset_valid", 32'(n_valid), 32'd0);
        chk("reset_mask", 32'(mask), 32'h0);
        chk("reset_dec", 32'(n_dec), 32'd0);
        chk("reset_sel", 32'(n_sel), 32'd0);

        send_digit(0, 4);
        chk("f1_mask_d0", 32'(mask), 32'h1);
        send_digit(1, 3);
        chk("f1_mask_d1", 32'(mask), 32'h3);
        send_digit(2, 2);
        chk("f1_mask_d2", 32'(mask), 32'h7);
        chk("f1_no_valid_yet", 32'(n_valid), 32'd0);
        send_digit(3, 1);
        chk("f1_valid_once", 32'(n_valid), 32'd1);
        chk("f1_number", 32'(number), 32'h1234);
        chk("f1_mask_clear", 32'(mask), 32'h0);

        send_digit(0, 5);
        send_digit(1, 6);
        send_digit(1, 7);
        chk("f2_mask_recap", 32'(mask), 32'h3);
        send_digit(2, 8);
        send_digit(3, 9);
        chk("f2_valid_once", 32'(n_valid), 32'd2);
        chk("f2_number", 32'(number), 32'h9875);
        chk("f2_mask_clear", 32'(mask), 32'h0);

        send_digit(0, 10);
        chk("sel_pre_mask", 32'(mask), 32'h1);
        send_raw(~glyph[1], ~8'b0000_0101);
        chk("sel_err_pulse", 32'(n_sel), 32'd1);
        chk("sel_mask_kept", 32'(mask), 32'h1);
        chk("sel_no_dec", 32'(n_dec), 32'd0);

        send_raw(8'hFF, ~8'h02);
        chk("dec_err_pulse", 32'(n_dec), 32'd1);
        chk("dec_mask_kept", 32'(mask), 32'h1);
        chk("dec_no_sel", 32'(n_sel), 32'd1);

        // Final shift edge lands when the settle counter sits at SETTLE_CYCLES-2.
        a_img = ~glyph[11];
        b_img = ~8'h02;
        for (int i = 7; i >= 1; i--) send_bit(a_img[i], b_img[i]);
        repeat (9) @(negedge clk);
        send_bit(a_img[0], b_img[0]);
        repeat (8) @(negedge clk);
        chk("restart_no_early_cap", 32'(mask), 32'h1);
        repeat (30) @(negedge clk);
        chk("restart_mask", 32'(mask), 32'h3);
        chk("restart_no_errs", 32'(n_dec + n_sel), 32'd2);
        send_digit(2, 12);
        send_digit(3, 13);
        chk("f3_valid", 32'(n_valid), 32'd3);
        chk("f3_number", 32'(number), 32'hDCBA);

        send_digit(0, 1);
        send_digit(1, 2);
        chk("rst_pre_mask", 32'(mask), 32'h3);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_mask", 32'(mask), 32'h0);
        chk("rst_mid_number", 32'(number), 32'h0);
        send_digit(2, 3);
        send_digit(3, 4);
        chk("rst_mid_no_valid", 32'(n_valid), 32'd3);
        chk("rst_mid_mask_after", 32'(mask), 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/numeric_led_display_monitor.md
# numeric_led_display_monitor

Receive-side counterpart of the 4-digit hex LED display driver. Snoops the two serial shift-register streams (segment stream A, digit-select stream B), rebuilds each register image on CP edges, decodes each multiplexed digit back to its hex nibble, and publishes the full 16-bit number once all four digits have been seen. Used for on-board loopback self-test and in simulation as the scoreboard front end for the display path.

## Interface
- SETTLE_CYCLES, 16: quiet i_clk cycles with no CP activity before shifter images are treated as stable (range 2..255).
- COMMON_ANODE, 1'b1: 1 inverts both received images before decode; 0 uses them as received (common cathode).

- i_clk  in  1  system clock (25 MHz); all logic on rising edge.
- i_reset_n  in  1  reset; asynchronous assert, active-low.
- i_shifter_a_ds  in  1  segment stream data.
- i_shifter_a_cp  in  1  segment stream shift clock (sampled, not used as a clock).
- i_shifter_a_mr_n  in  1  segment register clear, active-low.
- i_shifter_b_ds / i_shifter_b_cp / i_shifter_b_mr_n  in  1 each  same for digit-select stream.
- o_number  out  16  last complete number; D0 in [3:0] .. D3 in [15:12].
- o_valid  out  1  one-cycle pulse when o_number is updated.
- o_digit_mask  out  4  digits captured in the current, incomplete frame.
- o_decode_error  out  1  one-cycle pulse: selected digit's segment pattern is not a hex glyph.
- o_select_error  out  1  one-cycle pulse: digit-select image is not one-hot in bits [3:0].

## Operation
- All six pin inputs pass a 2-flop synchronizer; CP rising edges detected on synchronized value vs. its previous sample.
- Per stream an 8-bit image register: on CP rising edge image <= {image[6:0], ds}. Synchronized MR_n low clears image to 8'h00 and has priority over a simultaneous CP edge.
- After COMMON_ANODE inversion: stream A bits [7:1] = segments a..g, bit 0 = dp (ignored); stream B bits [3:0] = one-hot digit select D0..D3, bits [7:4] ignored.
- Glyph codes (a..g,dp): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=E6 A=EE B=3E C=9C D=7A E=9E F=8E; comparison on bits [7:1] only.
- FSM states: IDLE (no CP edge since last capture), SETTLE (counting quiet cycles), CAPTURE (one cycle).
  - IDLE -> SETTLE on any CP edge (A or B); counter <= 0.
  - SETTLE: CP edge on either stream restarts counter at 0; counter == SETTLE_CYCLES-1 -> CAPTURE.
  - CAPTURE: select not one-hot -> o_select_error, no store. One-hot but bad glyph -> o_decode_error, no store. Else store nibble in digit slot, set mask bit (re-capture of same digit overwrites). Always -> IDLE.
- When the mask becomes 4'hF: o_number <= four slots, o_valid pulses, mask clears in the same cycle.
- MR_n activity alone does not start SETTLE.

## Timing
- Reset values: o_number 16'h0000, o_valid 0, o_digit_mask 4'h0, both error outputs 0, images 8'h00, FSM IDLE, synchronizers 0.
- Input-to-edge-detect latency: 3 i_clk cycles after a pin transition.
- CAPTURE occurs SETTLE_CYCLES cycles after the last detected CP edge; o_valid / error pulses and o_digit_mask update in the cycle after CAPTURE.
- CP pulses must be high and low for at least 2 i_clk cycles each; narrower pulses undefined.
- Reset mid-frame discards partial slots and mask; no pulse emitted.

## Structure
- Shared package numeric_led_display_pkg: 16 glyph constants, NUM_DIGITS = 4, FSM state enum, segment bit-position constants (shared with the driver side).
- One sub-module: seven_seg_decoder (combinational: 7-bit pattern -> 4-bit nibble + valid flag), instantiated once on the muxed pattern.

## Test plan
- Reset, then idle pins -> all outputs hold reset values indefinitely.
- Drive frames for 0x1234 (COMMON_ANODE=1, inverted bits, 8 CP edges per stream per digit) -> o_valid one cycle, o_number = 16'h1234, mask 4'h0 after.
- Digits sent D0,D1,D1(new value 7),D2,D3 -> single o_valid, D1 holds 7.
- Select image 8'b0000_0101 -> o_select_error one cycle, mask unchanged.
- Segment pattern 8'hFF (inverted: 8'h00 pattern) -> o_decode_error, mask unchanged.
- CP edge arriving at counter = SETTLE_CYCLES-2 -> capture delayed full SETTLE_CYCLES from new edge; i_reset_n low after 2 digits -> mask 0, no o_valid.
